// File: rtl/stream_serializer.sv
// Wide-to-narrow valid/ready serializer: one RATIO-beat word per input handshake,
// emitted LS or MS slice first, with a one-word skid buffer so in_ready_o is a flop.
module stream_serializer #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned RATIO      = 4,
    parameter bit          LSB_FIRST  = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [DATA_WIDTH*RATIO-1:0]  in_data_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [DATA_WIDTH-1:0]        out_data_o,
    output logic                         out_last_o,
    output logic                         busy_o
);

    localparam int unsigned     WORD_W   = DATA_WIDTH * RATIO;
    localparam int unsigned     CNT_W    = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATIO - 1);

    logic [WORD_W-1:0] act_q, act_d;
    logic [WORD_W-1:0] pend_q, pend_d;
    logic              valid_q, valid_d;
    logic              pend_vld_q, pend_vld_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              in_ready_q;

    logic              in_fire;
    logic              out_fire;
    logic              cnt_last;
    logic [CNT_W-1:0]  sel;

    assign in_fire  = in_valid_i & in_ready_q;
    assign out_fire = valid_q & out_ready_i;
    assign cnt_last = (cnt_q == CNT_LAST);

    always_comb begin
        act_d      = act_q;
        pend_d     = pend_q;
        valid_d    = valid_q;
        pend_vld_d = pend_vld_q;
        cnt_d      = cnt_q;
        if (!valid_q) begin
            if (in_fire) begin
                act_d   = in_data_i;
                cnt_d   = '0;
                valid_d = 1'b1;
            end
        end else if (out_fire) begin
            if (!cnt_last) begin
                cnt_d = cnt_q + CNT_W'(1);
                if (in_fire) begin
                    pend_d     = in_data_i;
                    pend_vld_d = 1'b1;
                end
            end else if (pend_vld_q) begin
                act_d      = pend_q;
                pend_vld_d = 1'b0;
                cnt_d      = '0;
            end else if (in_fire) begin
                // Last beat leaves while a new word arrives: load it directly, no bubble.
                act_d = in_data_i;
                cnt_d = '0;
            end else begin
                valid_d = 1'b0;
                cnt_d   = '0;
            end
        end else if (in_fire) begin
            pend_d     = in_data_i;
            pend_vld_d = 1'b1;
        end
    end

    always_comb begin
        out_data_o = '0;
        sel        = LSB_FIRST ? cnt_q : (CNT_LAST - cnt_q);
        if (valid_q) begin
            for (int unsigned i = 0; i < RATIO; i++) begin
                if (sel == CNT_W'(i)) begin
                    out_data_o = act_q[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            act_q      <= '0;
            pend_q     <= '0;
            valid_q    <= 1'b0;
            pend_vld_q <= 1'b0;
            cnt_q      <= '0;
            in_ready_q <= 1'b1;
        end else begin
            act_q      <= act_d;
            pend_q     <= pend_d;
            valid_q    <= valid_d;
            pend_vld_q <= pend_vld_d;
            cnt_q      <= cnt_d;
            in_ready_q <= ~pend_vld_d;
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = valid_q;
    assign out_last_o  = valid_q & cnt_last;
    assign busy_o      = valid_q | pend_vld_q;

endmodule

// File: tb/tb_stream_serializer.sv
// Bench for stream_serializer: three instances (LSB-first, MSB-first, RATIO=1)
// checked every cycle against a queue-of-beats reference model.
module tb_stream_serializer;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_ready;

    logic       rdy0, vld0, lst0, bsy0;
    logic       rdy1, vld1, lst1, bsy1;
    logic       rdy2, vld2, lst2, bsy2;
    logic [7:0] dat0, dat1, dat2;

    int    checks   = 0;
    int    failures = 0;
    string phase    = "init";

    // Reference: each DUT holds a queue of pending beats {last, data} and a word count.
    logic [8:0] mq0[$];
    logic [8:0] mq1[$];
    logic [8:0] mq2[$];
    int         held0 = 0;
    int         held1 = 0;
    int         held2 = 0;

    stream_serializer #(.DATA_WIDTH(8), .RATIO(4), .LSB_FIRST(1'b1)) dut0 (
        .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(rdy0),
        .in_data_i(in_data), .out_valid_o(vld0), .out_ready_i(out_ready),
        .out_data_o(dat0), .out_last_o(lst0), .busy_o(bsy0));

    stream_serializer #(.DATA_WIDTH(8), .RATIO(4), .LSB_FIRST(1'b0)) dut1 (
        .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(rdy1),
        .in_data_i(in_data), .out_valid_o(vld1), .out_ready_i(out_ready),
        .out_data_o(dat1), .out_last_o(lst1), .busy_o(bsy1));

    stream_serializer #(.DATA_WIDTH(8), .RATIO(1), .LSB_FIRST(1'b1)) dut2 (
        .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(rdy2),
        .in_data_i(in_data[7:0]), .out_valid_o(vld2), .out_ready_i(out_ready),
        .out_data_o(dat2), .out_last_o(lst2), .busy_o(bsy2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        mq0.delete(); mq1.delete(); mq2.delete();
        held0 = 0; held1 = 0; held2 = 0;
    endtask

    task automatic model_push(input int which, input logic [31:0] w);
        int          n;
        logic [31:0] t;
        logic [7:0]  d;
        logic [8:0]  beat;
        n = (which == 2) ? 1 : 4;
        t = w;
        for (int b = 0; b < n; b++) begin
            if (which == 1) begin
                d = t[31:24];
                t = t << 8;
            end else begin
                d = t[7:0];
                t = t >> 8;
            end
            beat = {(b == n - 1), d};
            case (which)
                0:       mq0.push_back(beat);
                1:       mq1.push_back(beat);
                default: mq2.push_back(beat);
            endcase
        end
        case (which)
            0:       held0++;
            1:       held1++;
            default: held2++;
        endcase
    endtask

    task automatic model_pop(input int which);
        logic [8:0] b;
        case (which)
            0: begin b = mq0.pop_front(); if (b[8]) held0--; end
            1: begin b = mq1.pop_front(); if (b[8]) held1--; end
            default: begin b = mq2.pop_front(); if (b[8]) held2--; end
        endcase
    endtask

    task automatic cmp_dut(input string nm, input logic rdy, input logic vld,
                           input logic [7:0] dat, input logic lst, input logic bsy,
                           input int sz, input logic [8:0] fr, input int held);
        logic [7:0] edat;
        logic       elst;
        edat = (sz > 0) ? fr[7:0] : 8'h00;
        elst = (sz > 0) ? fr[8] : 1'b0;
        check({phase, ".", nm, ".in_ready"},  32'(rdy), 32'(held < 2));
        check({phase, ".", nm, ".out_valid"}, 32'(vld), 32'(sz > 0));
        check({phase, ".", nm, ".out_data"},  32'(dat), 32'(edat));
        check({phase, ".", nm, ".out_last"},  32'(lst), 32'(elst));
        check({phase, ".", nm, ".busy"},      32'(bsy), 32'(sz > 0));
    endtask

    task automatic compare_all();
        logic [8:0] f0, f1, f2;
        f0 = (mq0.size() > 0) ? mq0[0] : 9'h0;
        f1 = (mq1.size() > 0) ? mq1[0] : 9'h0;
        f2 = (mq2.size() > 0) ? mq2[0] : 9'h0;
        cmp_dut("d0", rdy0, vld0, dat0, lst0, bsy0, mq0.size(), f0, held0);
        cmp_dut("d1", rdy1, vld1, dat1, lst1, bsy1, mq1.size(), f1, held1);
        cmp_dut("d2", rdy2, vld2, dat2, lst2, bsy2, mq2.size(), f2, held2);
    endtask

    // Drive one cycle of inputs, advance the model at the edge, check 1 ns later.
    task automatic cycle(input logic iv, input logic [31:0] d, input logic ordy);
        logic fi0, fi1, fi2, fo0, fo1, fo2;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        fi0 = rst && iv && (held0 < 2);
        fi1 = rst && iv && (held1 < 2);
        fi2 = rst && iv && (held2 < 2);
        fo0 = rst && ordy && (mq0.size() > 0);
        fo1 = rst && ordy && (mq1.size() > 0);
        fo2 = rst && ordy && (mq2.size() > 0);
        @(posedge clk);
        if (!rst) begin
            model_clear();
        end else begin
            if (fo0) model_pop(0);
            if (fo1) model_pop(1);
            if (fo2) model_pop(2);
            if (fi0) model_push(0, d);
            if (fi1) model_push(1, d);
            if (fi2) model_push(2, {24'h0, d[7:0]});
        end
        #1;
        compare_all();
    endtask

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        phase = "reset";
        for (int i = 0; i < 8; i++) begin
            cycle(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
        end
        #3 rst = 1'b1;

        phase = "single";
        cycle(1'b1, 32'hDDCCBBAA, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b0, 32'h0, 1'b1);

        phase = "b2b";
        cycle(1'b1, 32'h44332211, 1'b1);
        cycle(1'b1, 32'h88776655, 1'b1);
        for (int i = 0; i < 9; i++) cycle(1'b0, 32'h0, 1'b1);

        phase = "stall";
        cycle(1'b1, 32'hDDCCBBAA, 1'b1);
        cycle(1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 32'h0, 1'b1);

        phase = "rstmid";
        cycle(1'b1, 32'hCAFEF00D, 1'b1);
        cycle(1'b0, 32'h0, 1'b1);
        cycle(1'b0, 32'h0, 1'b1);
        #3 rst = 1'b0;
        #1 model_clear();
        compare_all();
        cycle(1'b1, 32'h12345678, 1'b1);
        cycle(1'b0, 32'h0, 1'b1);
        #3 rst = 1'b1;
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b1);
        cycle(1'b1, 32'h0BADBEEF, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b0, 32'h0, 1'b1);

        phase = "rand";
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 3) != 0));
        end

        phase = "randstall";
        for (int i = 0; i < 200; i++) begin
            cycle(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 3) == 0));
        end

        phase = "drain";
        for (int i = 0; i < 20; i++) cycle(1'b0, 32'h0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
